// File: rtl/fifo_rd_pkg.sv
// Shared constants and state encoding for the FIFO burst reader.
package fifo_rd_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned BURST_CNT_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer: a registered output stage backed by one skid register.
module rd_skid_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready_c,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [1:0]        level_c
);

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              load;

    // Output stage may take a new word when it is empty or being consumed.
    assign load      = !m_valid || m_ready;
    assign s_ready_c = !skid_valid || load;
    assign level_c   = 2'(m_valid) + 2'(skid_valid);

    // Oldest word always sits in the output stage; the skid holds the younger one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (load) begin
            if (skid_valid) begin
                m_valid    <= 1'b1;
                m_data     <= skid_data;
                skid_valid <= s_valid;
                if (s_valid) begin
                    skid_data <= s_data;
                end
            end else begin
                m_valid <= s_valid;
                if (s_valid) begin
                    m_data <= s_data;
                end
            end
        end else if (s_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a FIFO in bursts once its occupancy crosses a threshold (or it fills).
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned THRESH = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [DATA_W-1:0]      fifo_dout,
    input  logic                   fifo_empty,
    input  logic                   fifo_full,
    input  logic [CNT_W-1:0]       fifo_data_count,
    output logic                   fifo_rd_en,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   burst_active,
    output logic [BURST_CNT_W-1:0] burst_cnt
);

    rd_state_e  state;
    logic       rd_inflight;
    logic       buf_s_ready;
    logic       buf_pop;
    logic [1:0] buf_level;
    logic [2:0] pending;
    logic       start_burst;
    logic       end_burst;

    // Words that will occupy the buffer next cycle, counting the in-flight read.
    assign buf_pop     = m_valid & m_ready;
    assign pending     = 3'(buf_level) - 3'(buf_pop) + 3'(rd_inflight);

    // Read only in BURST, only from a non-empty FIFO, and only if the word will fit.
    assign fifo_rd_en  = sys_rst_n & (state == BURST) & !fifo_empty
                         & buf_s_ready & (pending < 3'd2);

    assign start_burst = (fifo_data_count >= CNT_W'(THRESH)) | fifo_full;
    assign end_burst   = fifo_empty & !fifo_rd_en & !rd_inflight;

    // Burst FSM with registered status outputs and the one-cycle read-latency tracker.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            burst_active <= 1'b0;
            burst_cnt    <= '0;
            rd_inflight  <= 1'b0;
        end else begin
            rd_inflight <= fifo_rd_en;
            case (state)
                IDLE: begin
                    if (start_burst) begin
                        state        <= BURST;
                        burst_active <= 1'b1;
                        burst_cnt    <= burst_cnt + BURST_CNT_W'(1);
                    end
                end
                BURST: begin
                    if (end_burst) begin
                        state        <= IDLE;
                        burst_active <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Read data lands one cycle after the strobe and is captured into the buffer.
    rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .s_valid   (rd_inflight),
        .s_data    (fifo_dout),
        .s_ready_c (buf_s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .level_c   (buf_level)
    );

endmodule
